// File: rtl/fc_psum_accum.sv
// FC-column partial-sum accumulator: sums tiles of psums per output neuron,
// adds bias, applies optional ReLU, requantises to int8 and queues results.
module fc_psum_accum #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [7:0]         cfg_num_tiles_i,
    input  logic [7:0]         cfg_num_out_i,
    input  logic signed [31:0] cfg_bias_i,
    input  logic [4:0]         cfg_shift_i,
    input  logic               cfg_relu_i,
    input  logic               psum_valid_i,
    input  logic signed [31:0] psum_i,
    output logic               psum_ready_o,
    output logic               out_valid_o,
    output logic [7:0]         out_data_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_QUANT = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic signed [32:0] SAT_MAX = 33'sd127;
    localparam logic signed [32:0] SAT_MIN = -33'sd128;

    logic [1:0]         r_state;
    logic [7:0]         r_tiles;
    logic [7:0]         r_nout;
    logic signed [31:0] r_bias;
    logic [4:0]         r_shift;
    logic               r_relu;
    logic signed [31:0] r_acc;
    logic [7:0]         r_tile_cnt;
    logic [7:0]         r_neuron_cnt;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [7:0]         r_last;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_accept;
    logic signed [31:0] w_s;
    logic signed [32:0] w_s_ext;
    logic signed [32:0] w_rnd;
    logic signed [32:0] w_sum33;
    logic signed [32:0] w_r;
    logic [7:0]         w_q;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop    = !w_empty && out_ready_i;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign w_push   = (r_state == ST_QUANT) && (!w_full || w_pop);
    assign w_accept = (r_state == ST_ACCUM) && psum_valid_i;

    assign psum_ready_o = (r_state == ST_ACCUM);
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DRAIN) && w_empty;
    assign out_valid_o  = !w_empty;
    assign out_data_o   = w_empty ? r_last : r_mem[r_rd_ptr[AW-1:0]];

    // Requantisation: bias, ReLU, round-half-up shift in 33 bits, saturate.
    always_comb begin
        w_s = r_acc + r_bias;
        if (r_relu && w_s[31]) begin
            w_s = 32'sd0;
        end
        w_s_ext = {w_s[31], w_s};
        w_rnd   = (r_shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (r_shift - 5'd1));
        w_sum33 = w_s_ext + w_rnd;
        w_r     = (r_shift == 5'd0) ? w_s_ext : (w_sum33 >>> r_shift);
        if (w_r > SAT_MAX) begin
            w_q = 8'h7F;
        end else if (w_r < SAT_MIN) begin
            w_q = 8'h80;
        end else begin
            w_q = w_r[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tiles      <= 8'd0;
            r_nout       <= 8'd0;
            r_bias       <= 32'sd0;
            r_shift      <= 5'd0;
            r_relu       <= 1'b0;
            r_acc        <= 32'sd0;
            r_tile_cnt   <= 8'd0;
            r_neuron_cnt <= 8'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_last       <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_tiles      <= (cfg_num_tiles_i == 8'd0) ? 8'd1 : cfg_num_tiles_i;
                        r_nout       <= (cfg_num_out_i == 8'd0) ? 8'd1 : cfg_num_out_i;
                        r_bias       <= cfg_bias_i;
                        r_shift      <= cfg_shift_i;
                        r_relu       <= cfg_relu_i;
                        r_acc        <= 32'sd0;
                        r_tile_cnt   <= 8'd0;
                        r_neuron_cnt <= 8'd0;
                        r_state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc      <= r_acc + psum_i;
                        r_tile_cnt <= r_tile_cnt + 8'd1;
                        if (r_tile_cnt == r_tiles - 8'd1) begin
                            r_state <= ST_QUANT;
                        end
                    end
                end
                ST_QUANT: begin
                    if (w_push) begin
                        r_acc        <= 32'sd0;
                        r_tile_cnt   <= 8'd0;
                        r_neuron_cnt <= r_neuron_cnt + 8'd1;
                        r_state      <= (r_neuron_cnt == r_nout - 8'd1) ? ST_DRAIN : ST_ACCUM;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_psum_accum.sv
// Directed self-checking bench for fc_psum_accum: reset, basic layer, ReLU/saturation,
// rounding/wrap, backpressure, mid-layer reset and ignored restart.
module tb_fc_psum_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  cfg_num_tiles_i;
    logic [7:0]  cfg_num_out_i;
    logic [31:0] cfg_bias_i;
    logic [4:0]  cfg_shift_i;
    logic        cfg_relu_i;
    logic        psum_valid_i;
    logic [31:0] psum_i;
    logic        psum_ready_o;
    logic        out_valid_o;
    logic [7:0]  out_data_o;
    logic        out_ready_i;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_fails  = 0;
    int n_done   = 0;
    logic [7:0] q_out [$];

    always #5 clk = ~clk;

    fc_psum_accum #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .cfg_num_tiles_i (cfg_num_tiles_i),
        .cfg_num_out_i   (cfg_num_out_i),
        .cfg_bias_i      (cfg_bias_i),
        .cfg_shift_i     (cfg_shift_i),
        .cfg_relu_i      (cfg_relu_i),
        .psum_valid_i    (psum_valid_i),
        .psum_i          (psum_i),
        .psum_ready_o    (psum_ready_o),
        .out_valid_o     (out_valid_o),
        .out_data_o      (out_data_o),
        .out_ready_i     (out_ready_i),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    // Record every popped entry and every done pulse.
    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) q_out.push_back(out_data_o);
        if (rst_n && done_o) n_done++;
    end

    task automatic do_start(input logic [7:0] t, input logic [7:0] o, input logic [31:0] b,
                            input logic [4:0] s, input logic r);
        cfg_num_tiles_i = t;
        cfg_num_out_i   = o;
        cfg_bias_i      = b;
        cfg_shift_i     = s;
        cfg_relu_i      = r;
        start_i         = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic send_psum(input logic [31:0] v);
        int n;
        n = 0;
        psum_valid_i = 1'b1;
        psum_i       = v;
        @(negedge clk);
        while (!psum_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!psum_ready_o) begin
            n_checks++;
            n_fails++;
            $display("FAIL psum_accept_timeout: psum_ready_o=%0b required 1", psum_ready_o);
        end else begin
            @(posedge clk);
            #1;
        end
        psum_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            n_checks++;
            n_fails++;
            $display("FAIL idle_timeout: busy_o=%0b required 0", busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (psum_ready_o !== 1'b0) begin
            n_fails++; $display("FAIL reset_psum_ready: got %0b want 0", psum_ready_o);
        end
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid_o);
        end
        n_checks++;
        if (out_data_o !== 8'h00) begin
            n_fails++; $display("FAIL reset_out_data: got %h want 00", out_data_o);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fails++; $display("FAIL reset_busy: got %0b want 0", busy_o);
        end
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fails++; $display("FAIL reset_done: got %0b want 0", done_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        q_out.delete();
        out_ready_i = 1'b0;
        do_start(8'd3, 8'd1, 32'd10, 5'd2, 1'b0);
        send_psum(32'd100);
        send_psum(32'd200);
        send_psum(-32'sd50);
        // One cycle after the last accept: QUANT, nothing pushed yet.
        @(negedge clk);
        n_checks++;
        if (psum_ready_o !== 1'b0 || busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_quant_cycle: ready=%0b busy=%0b valid=%0b want 0 1 0",
                     psum_ready_o, busy_o, out_valid_o);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'd65) begin
            n_fails++;
            $display("FAIL basic_result: valid=%0b data=%0d want 1 65", out_valid_o, out_data_o);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'd65 || done_o !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_hold: valid=%0b data=%0d done=%0b want 1 65 0",
                     out_valid_o, out_data_o, done_o);
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b1 || out_valid_o !== 1'b0 || out_data_o !== 8'd65) begin
            n_fails++;
            $display("FAIL basic_done: done=%0b valid=%0b data=%0d want 1 0 65",
                     done_o, out_valid_o, out_data_o);
        end
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_idle: done=%0b busy=%0b want 0 0", done_o, busy_o);
        end
        n_checks++;
        if (q_out.size() != 1) begin
            n_fails++; $display("FAIL basic_count: got %0d want 1", q_out.size());
        end
    endtask

    task automatic test_relu_sat();
        logic [7:0] exp_relu [3];
        logic [7:0] exp_raw  [3];
        exp_relu = '{8'h00, 8'h7F, 8'h00};
        exp_raw  = '{8'hFB, 8'h7F, 8'h80};
        for (int pass = 0; pass < 2; pass++) begin
            q_out.delete();
            out_ready_i = 1'b1;
            do_start(8'd1, 8'd3, 32'd0, 5'd0, (pass == 0));
            send_psum(-32'sd5);
            send_psum(32'd300);
            send_psum(-32'sd300);
            wait_idle();
            n_checks++;
            if (q_out.size() != 3) begin
                n_fails++;
                $display("FAIL relu_sat_count pass %0d: got %0d want 3", pass, q_out.size());
            end
            for (int i = 0; i < 3; i++) begin
                logic [7:0] e;
                e = (pass == 0) ? exp_relu[i] : exp_raw[i];
                n_checks++;
                if (i >= q_out.size() || q_out[i] !== e) begin
                    n_fails++;
                    $display("FAIL relu_sat pass %0d idx %0d: got %h want %h", pass, i,
                             (i < q_out.size()) ? q_out[i] : 8'hxx, e);
                end
            end
        end
    endtask

    task automatic test_round_wrap();
        q_out.delete();
        out_ready_i = 1'b1;
        // Zero tiles and zero outputs both behave as 1.
        do_start(8'd0, 8'd0, 32'd0, 5'd1, 1'b0);
        send_psum(-32'sd3);
        wait_idle();
        do_start(8'd1, 8'd1, 32'd1, 5'd1, 1'b0);
        send_psum(32'h7FFF_FFFF);
        wait_idle();
        n_checks++;
        if (q_out.size() != 2) begin
            n_fails++; $display("FAIL round_wrap_count: got %0d want 2", q_out.size());
        end
        n_checks++;
        if (q_out.size() < 1 || q_out[0] !== 8'hFF) begin
            n_fails++; $display("FAIL round_neg: got %h want ff", (q_out.size() > 0) ? q_out[0] : 8'hxx);
        end
        n_checks++;
        if (q_out.size() < 2 || q_out[1] !== 8'h80) begin
            n_fails++; $display("FAIL wrap_sat: got %h want 80", (q_out.size() > 1) ? q_out[1] : 8'hxx);
        end
    endtask

    task automatic test_backpressure();
        q_out.delete();
        out_ready_i = 1'b0;
        do_start(8'd1, 8'd6, 32'd0, 5'd0, 1'b0);
        for (int i = 1; i <= 5; i++) send_psum(32'(i));
        repeat (2) @(negedge clk);
        n_checks++;
        if (psum_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_stall: ready=%0b busy=%0b want 0 1", psum_ready_o, busy_o);
        end
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'd1) begin
            n_fails++;
            $display("FAIL bp_head: valid=%0b data=%0d want 1 1", out_valid_o, out_data_o);
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        send_psum(32'd6);
        wait_idle();
        n_checks++;
        if (q_out.size() != 6) begin
            n_fails++; $display("FAIL bp_count: got %0d want 6", q_out.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= q_out.size() || q_out[i] !== 8'(i + 1)) begin
                n_fails++;
                $display("FAIL bp_order idx %0d: got %h want %h", i,
                         (i < q_out.size()) ? q_out[i] : 8'hxx, 8'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b0;
        do_start(8'd1, 8'd4, 32'd0, 5'd0, 1'b0);
        send_psum(32'd11);
        send_psum(32'd22);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || psum_ready_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid: busy=%0b valid=%0b ready=%0b want 0 0 0",
                     busy_o, out_valid_o, psum_ready_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_out.delete();
        out_ready_i = 1'b1;
        do_start(8'd2, 8'd1, 32'd0, 5'd0, 1'b0);
        send_psum(32'd7);
        send_psum(32'd8);
        wait_idle();
        n_checks++;
        if (q_out.size() != 1 || q_out[0] !== 8'd15) begin
            n_fails++;
            $display("FAIL reset_fresh: count=%0d first=%h want 1 0f", q_out.size(),
                     (q_out.size() > 0) ? q_out[0] : 8'hxx);
        end
    endtask

    task automatic test_start_ignored();
        int d0;
        q_out.delete();
        out_ready_i = 1'b1;
        d0 = n_done;
        do_start(8'd2, 8'd2, 32'd0, 5'd0, 1'b0);
        do_start(8'd1, 8'd1, 32'd100, 5'd3, 1'b1);
        for (int i = 1; i <= 4; i++) send_psum(32'(i));
        wait_idle();
        n_checks++;
        if (q_out.size() != 2) begin
            n_fails++; $display("FAIL restart_count: got %0d want 2", q_out.size());
        end
        n_checks++;
        if (q_out.size() < 2 || q_out[0] !== 8'd3 || q_out[1] !== 8'd7) begin
            n_fails++;
            $display("FAIL restart_values: got %h %h want 03 07",
                     (q_out.size() > 0) ? q_out[0] : 8'hxx, (q_out.size() > 1) ? q_out[1] : 8'hxx);
        end
        n_checks++;
        if (n_done - d0 != 1) begin
            n_fails++; $display("FAIL restart_done_pulses: got %0d want 1", n_done - d0);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        start_i         = 1'b0;
        cfg_num_tiles_i = 8'd0;
        cfg_num_out_i   = 8'd0;
        cfg_bias_i      = 32'd0;
        cfg_shift_i     = 5'd0;
        cfg_relu_i      = 1'b0;
        psum_valid_i    = 1'b0;
        psum_i          = 32'd0;
        out_ready_i     = 1'b0;
        test_reset();
        test_basic();
        test_relu_sat();
        test_round_wrap();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fc_psum_accum.md
FC_PSUM_ACCUM -- requirements
Module: fc_psum_accum

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start_i  input  1  one-cycle pulse; latches all cfg_* inputs and begins a layer.
REQ-005 cfg_num_tiles_i  input  8  psums accumulated per output neuron; 0 treated as 1.
REQ-006 cfg_num_out_i  input  8  output neurons per layer; 0 treated as 1.
REQ-007 cfg_bias_i  input  32  signed bias added to each neuron sum.
REQ-008 cfg_shift_i  input  5  requantisation right-shift amount.
REQ-009 cfg_relu_i  input  1  1 = clamp negative biased sums to 0.
REQ-010 psum_valid_i  input  1  psum_i valid from the last PE row of the FC column.
REQ-011 psum_i  input  32  signed partial sum.
REQ-012 psum_ready_o  output  1  psum accepted when psum_valid_i and psum_ready_o are both 1.
REQ-013 out_valid_o  output  1  FIFO head valid.
REQ-014 out_data_o  output  8  signed int8 result at FIFO head.
REQ-015 out_ready_i  input  1  downstream pops on out_valid_o and out_ready_i.
REQ-016 busy_o  output  1  1 in every state except IDLE.
REQ-017 done_o  output  1  one-cycle pulse on layer completion.

Function
REQ-018 States: IDLE, ACCUM, QUANT, DRAIN.
REQ-019 IDLE to ACCUM on start_i; cfg latched; acc cleared; tile and neuron counters cleared.
REQ-020 start_i outside IDLE shall be ignored; latched cfg unchanged.
REQ-021 psum_ready_o shall be 1 only in ACCUM.
REQ-022 ACCUM: each accepted psum adds to a 32-bit acc (two's complement, wraps mod 2^32); tile counter increments.
REQ-023 On the accept that completes cfg_num_tiles psums, next state shall be QUANT.
REQ-024 QUANT: s = acc + bias (32-bit wrap); if relu and s<0 then s=0.
REQ-025 QUANT: if shift>0, r = (s + 2^(shift-1)) >>> shift, computed in 33 bits with no wrap; if shift=0, r = s.
REQ-026 QUANT: r saturated to [-128,127] and pushed to FIFO.
REQ-027 QUANT with FIFO full and no same-cycle pop shall stall: no push, stay in QUANT.
REQ-028 A push into a full FIFO coinciding with a pop shall succeed.
REQ-029 After the push, acc and tile counter clear and the neuron counter increments.
REQ-030 After the push: next state ACCUM if neurons remain, else DRAIN.
REQ-031 Push latency: the first QUANT cycle follows the final accepted psum by exactly 1 clk.
REQ-032 Push-to-visible: a pushed entry is visible at out_data_o on the next cycle when the FIFO was empty.
REQ-033 FIFO: first-in first-out; out_data_o and out_valid_o held stable while out_valid_o=1 and out_ready_i=0.
REQ-034 Empty FIFO: out_valid_o=0; out_data_o holds its last value.
REQ-035 DRAIN: when the FIFO is empty, done_o pulses for 1 cycle and next state is IDLE.

Reset
REQ-036 rst_n=0 at any edge, including mid-layer: state IDLE; acc, counters and FIFO pointers 0.
REQ-037 Under reset: psum_ready_o, out_valid_o, out_data_o, busy_o and done_o are 0.
REQ-038 Under reset all FIFO contents are discarded.

Verification
REQ-039 Basic: tiles=3, out=1, bias=10, shift=2, relu=0, psums 100,200,-50 -> out_data_o=65, then done_o 1 cycle after pop.
REQ-040 ReLU/saturation: tiles=1, out=3, bias=0, shift=0, relu=1, psums -5,300,-300 -> outputs 0,127,0; with relu=0 -> 0xFB(-5),127,-128.
REQ-041 Backpressure: FIFO_DEPTH=4, out=6, out_ready_i=0 -> 4 entries held, psum_ready_o=0 in QUANT stall; release -> all 6 outputs in order, no loss or duplicate.
REQ-042 Rounding/wrap: shift=1, psum=-3, bias=0 -> -1; psum=0x7FFFFFFF, bias=1 -> acc wraps to -2^31 -> -128.
REQ-043 Reset mid-layer: assert rst_n=0 during ACCUM with 2 FIFO entries -> next cycle busy_o=0, out_valid_o=0; a fresh start then runs cleanly.
REQ-044 start_i pulsed while busy -> ignored; output count and values match the original cfg.
